// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train / edge generator.
// After an accepted start, drives `signal` through N high/low pulses of
// configurable phase lengths, with a one-cycle strobe on each edge it creates
// and a one-cycle `done` at the end of the train.
// Optional feature macro: PULSE_TRAIN_ABORT_EN. When defined, `abort` cancels a
// train in progress. When undefined, `abort` is ignored.
module pulse_train_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] high_cycles,
  input  logic [CNT_WIDTH-1:0] low_cycles,
  input  logic [NUM_WIDTH-1:0] pulse_count,
  input  logic                 abort,
  output logic                 ready,
  output logic                 signal,
  output logic                 rise_strobe,
  output logic                 fall_strobe,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_WIDTH-1:0] NUM_ZERO = {NUM_WIDTH{1'b0}};
  localparam logic [NUM_WIDTH-1:0] NUM_ONE  = {{(NUM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A zero-length phase is stretched to one cycle so a phase never vanishes.
  function automatic logic [CNT_WIDTH-1:0] clamp_len(input logic [CNT_WIDTH-1:0] len);
    return (len == CNT_ZERO) ? CNT_ONE : len;
  endfunction

  state_t                state_r, state_s;
  logic [CNT_WIDTH-1:0]  phase_cnt_r, phase_cnt_s;
  logic [NUM_WIDTH-1:0]  pulse_cnt_r, pulse_cnt_s;
  logic [CNT_WIDTH-1:0]  high_len_r, high_len_s;
  logic [CNT_WIDTH-1:0]  low_len_r, low_len_s;
  logic                  signal_r;
  logic                  rise_r;
  logic                  fall_r;
  logic                  done_r;
  logic                  ready_r;
  logic                  abort_s;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_s = abort;
`else
  logic unused_abort_s;
  assign abort_s        = 1'b0;
  assign unused_abort_s = abort;
`endif

  // Next-state, counter and config-latch logic for the pulse sequencer.
  always_comb begin
    state_s     = state_r;
    phase_cnt_s = phase_cnt_r;
    pulse_cnt_s = pulse_cnt_r;
    high_len_s  = high_len_r;
    low_len_s   = low_len_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          high_len_s  = clamp_len(high_cycles);
          low_len_s   = clamp_len(low_cycles);
          pulse_cnt_s = pulse_count;
          if (pulse_count == NUM_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s     = ST_HIGH;
            // Counter holds cycles remaining after the current one.
            phase_cnt_s = clamp_len(high_cycles) - CNT_ONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (abort_s) begin
          state_s     = ST_IDLE;
          phase_cnt_s = CNT_ZERO;
          pulse_cnt_s = NUM_ZERO;
        end else if (phase_cnt_r == CNT_ZERO) begin
          state_s     = ST_LOW;
          phase_cnt_s = low_len_r - CNT_ONE;
        end else begin
          phase_cnt_s = phase_cnt_r - CNT_ONE;
        end
      end
      ST_LOW: begin
        if (abort_s) begin
          state_s     = ST_IDLE;
          phase_cnt_s = CNT_ZERO;
          pulse_cnt_s = NUM_ZERO;
        end else if (phase_cnt_r == CNT_ZERO) begin
          // Pulse counter saturates at zero rather than wrapping.
          if (pulse_cnt_r != NUM_ZERO) begin
            pulse_cnt_s = pulse_cnt_r - NUM_ONE;
          end else begin
            pulse_cnt_s = NUM_ZERO;
          end
          if (pulse_cnt_r <= NUM_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s     = ST_HIGH;
            phase_cnt_s = high_len_r - CNT_ONE;
          end
        end else begin
          phase_cnt_s = phase_cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s     = ST_IDLE;
        phase_cnt_s = CNT_ZERO;
        pulse_cnt_s = NUM_ZERO;
      end
    endcase
  end

  // State/counter registers plus outputs registered from the next state so
  // that strobes line up exactly with the signal transition cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= CNT_ZERO;
      pulse_cnt_r <= NUM_ZERO;
      high_len_r  <= CNT_ZERO;
      low_len_r   <= CNT_ZERO;
      signal_r    <= 1'b0;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      phase_cnt_r <= phase_cnt_s;
      pulse_cnt_r <= pulse_cnt_s;
      high_len_r  <= high_len_s;
      low_len_r   <= low_len_s;
      signal_r    <= (state_s == ST_HIGH);
      rise_r      <= (state_s == ST_HIGH) && !signal_r;
      fall_r      <= (state_s != ST_HIGH) && signal_r;
      done_r      <= (state_s == ST_DONE);
      ready_r     <= (state_s == ST_IDLE);
    end
  end

  assign ready       = ready_r;
  assign signal      = signal_r;
  assign rise_strobe = rise_r;
  assign fall_strobe = fall_r;
  assign done        = done_r;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse/edge generator for the NIC's common library: on a start handshake it drives a single-bit output through N high/low cycles of configurable lengths, with a one-cycle strobe on each rising and falling edge it creates. It is the transmit-side counterpart to the edge detector. The edge detector observes transitions on a signal; this block produces them. Typical uses are MDC-style management clocks, LED blink patterns, and PHY reset/strobe sequences.

## Interface
- `CNT_WIDTH`, 16: width of the high/low phase length fields.
- `NUM_WIDTH`, 8: width of the pulse count field.

- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  request; accepted only when `ready`=1.
- `high_cycles`  in  CNT_WIDTH  high-phase length in cycles; sampled at accept.
- `low_cycles`  in  CNT_WIDTH  low-phase length in cycles; sampled at accept.
- `pulse_count`  in  NUM_WIDTH  number of pulses N; sampled at accept.
- `abort`  in  1  cancel the train in progress; functional only with `PULSE_TRAIN_ABORT_EN`.
- `ready`  out  1  idle, able to accept `start`.
- `signal`  out  1  generated waveform, registered.
- `rise_strobe`  out  1  1 in the first cycle `signal` is high after a low.
- `fall_strobe`  out  1  1 in the first cycle `signal` is low after a high.
- `done`  out  1  one-cycle completion pulse, registered.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - `ready`=1.
  - On `start`, latch the three config fields.
  - If N=0, go to DONE.
  - Otherwise go to HIGH, load the phase counter, and load the pulse counter with N.
- HIGH:
  - `signal`=1 for exactly max(`high_cycles`,1) cycles.
  - Then go to LOW.
- LOW:
  - `signal`=0 for exactly max(`low_cycles`,1) cycles.
  - Then decrement the pulse counter.
  - If it was the last pulse, go to DONE; otherwise go to HIGH.
- DONE:
  - `done`=1 for one cycle, `ready`=0.
  - Then go to IDLE.
- Zero-length phase fields are treated as 1, so a phase never vanishes.
- Phase counter: CNT_WIDTH, down-counting. Pulse counter: NUM_WIDTH. No wrap: a counter is never decremented past its terminal value.
- `start` while `ready`=0 is ignored; it is not queued.
- The config inputs may change freely after acceptance.
- `rise_strobe`/`fall_strobe` are registered and coincide exactly with the `signal` transition cycle.

## Timing
- Reset values (registered, take effect the cycle after `reset` is sampled high):
  - `signal`=0, `rise_strobe`=0, `fall_strobe`=0, `done`=0.
  - `ready`=1; FSM in IDLE, counters 0.
- Accept at cycle T with N≥1, H=max(high,1), L=max(low,1):
  - `signal` rises at T+1.
  - Pulse k (0-based) is high during cycles T+1+k(H+L) … T+k(H+L)+H.
  - `done`=1 at T+1+N(H+L); `ready`=1 from T+2+N(H+L).
  - A back-to-back `start` is accepted in that same cycle.
- Accept with N=0: `done`=1 at T+1, `ready`=1 at T+2, `signal` stays 0, no strobes.
- Reset mid-train wins over everything. Outputs take reset values next cycle, and no `fall_strobe` or `done` is emitted.
- `rise_strobe` and `fall_strobe` are never both 1 in the same cycle.

## Configuration
- Macro: `PULSE_TRAIN_ABORT_EN`.
- **Defined:** `abort`=1 in HIGH or LOW has the following effect on the next cycle:
  - `signal`=0.
  - `fall_strobe`=1 if `signal` was 1.
  - FSM returns to IDLE, `ready`=1, and no `done` is generated.
- **Defined:** `abort` in IDLE or DONE has no effect.
- **Not defined:** the `abort` port remains present but is ignored. Every train runs to completion and ends with `done`.

## Test plan
- High=2, low=3, N=2, `start` at cycle 0 -> the following response:
  - `signal` is 1 in cycles 1–2 and 6–7, 0 elsewhere.
  - `rise_strobe` is 1 at cycles 1 and 6.
  - `fall_strobe` is 1 at cycles 3 and 8.
  - `done` is 1 at cycle 11 only; `ready` returns at cycle 12.
- N=0, `start` at 0 -> `done` at 1, `ready` at 2, `signal`/strobes never 1.
- High=0, low=0, N=3, `start` at 0 -> `signal` is 1,0,1,0,1,0 over cycles 1–6, `done` at 7.
- High=5, low=5, N=4, second `start` at cycle 3 with N=1 -> ignored; exactly 4 pulses, `done` at 41.
- High=4, low=4, N=3, `reset` asserted at cycle 6 -> `signal`=0 and `ready`=1 from 7, no `fall_strobe`, no `done`.
- With `PULSE_TRAIN_ABORT_EN`: high=4, low=4, N=3, `abort` at cycle 2 -> the following response:
  - `signal`=0 and `fall_strobe`=1 at cycle 3.
  - `ready`=1 at cycle 3.
  - `done` never asserted.
- Without the macro, the same stimulus produces the full 3-pulse train with `done` at 25.
